seq_gen_core_sync: RTL and testbench
====================================

Name: seq_gen_core_sync

Overview:
- Single-clock sequence generator: bus-writable pattern memory played out word-by-word on SEQ_OUT.
- Playback starts on a bus start command or on SEQ_EXT_START, with a programmable word count, repeat count and inter-repeat gap.
- Transmit-side counterpart of the sequence recorder. Recorded data can be replayed byte-for-byte with the same memory byte order.
- Sits on the standard 8-bit register bus. Pattern memory is at addresses 16 .. 16+MEM_BYTES-1.

Parameters:
- MEM_BYTES, 8*1024, pattern memory size in bytes (power of two).
- ABUSWIDTH, 16, bus address width.
- OUT_BITS, 8, SEQ_OUT width; legal values 8, 16, 32.

Ports:
- BUS_CLK  in  1  single clock for bus and sequencer.
- BUS_RST  in  1  asynchronous reset, active-high.
- BUS_ADD  in  ABUSWIDTH  bus address.
- BUS_DATA_IN  in  8  bus write data.
- BUS_RD  in  1  bus read strobe.
- BUS_WR  in  1  bus write strobe.
- BUS_DATA_OUT  out  8  bus read data.
- SEQ_EXT_START  in  1  external trigger, sampled every cycle.
- SEQ_OUT  out  OUT_BITS  pattern output, registered.
- SEQ_BUSY  out  1  high while in RUN or WAIT.

Behaviour:
- Register map:
  - 0: write = soft reset (data ignored); read = VERSION (0).
  - 1: write = START; read = {7'b0, DONE}.
  - 2: bit0 EN_EXT_START.
  - 3/4: SIZE[7:0]/SIZE[15:8], words per pass.
  - 5: REPEAT, passes; 0 = loop forever.
  - 6/7: WAIT[7:0]/WAIT[15:8], gap cycles between passes.
  - 8-15: general R/W.
- Reset values:
  - BUS_RST (async) or soft reset (sync) clears all registers, except SIZE = MEM_BYTES/(OUT_BITS/8) and REPEAT = 1.
  - DONE = 1, state IDLE, SEQ_OUT = 0, SEQ_BUSY = 0.
- Bus reads:
  - BUS_DATA_OUT is valid the cycle after BUS_RD.
  - It is selected by the address latched with BUS_RD: register (<16), memory byte (<16+MEM_BYTES), else 0.
- Memory:
  - Dual-port with synchronous read. Bus port R/W, sequencer port read-only.
  - Word k spans bytes k*N .. k*N+N-1 (N = OUT_BITS/8). The lowest address is the MSB (big-endian).
  - Read-during-write on the sequencer port returns old data.
- Sequencer state machine:
  - IDLE: SEQ_OUT = 0.
    - Go to RUN on START, or on EN_EXT_START & SEQ_EXT_START.
    - On entry to RUN: word pointer = 0, pass counter = 0, DONE cleared.
    - If SIZE = 0, stay IDLE and keep DONE = 1.
  - RUN: read word pointer, increment each cycle.
    - After word SIZE-1, increment the pass counter.
    - If REPEAT != 0 and the pass counter reaches REPEAT, go to IDLE and set DONE.
    - Otherwise go to WAIT if WAIT > 0, else restart directly at word 0 with no gap cycle.
  - WAIT: SEQ_OUT = 0 for exactly WAIT cycles, then back to RUN at word 0.
- Latency: trigger sampled at edge T -> word k on SEQ_OUT after edge T+2+k.
  - The last word is held for one cycle, then SEQ_OUT returns to 0 (IDLE/WAIT).
  - DONE reads 1 from the cycle after the last word.
- Word pointer width is clog2(MEM_BYTES/N). SIZE larger than memory depth wraps the pointer modulo depth.
- Triggers while busy:
  - Bus START restarts immediately from word 0 with counters reloaded.
  - SEQ_EXT_START while busy is ignored.
  - Simultaneous START and EXT_START count as one start.
- Soft reset or BUS_RST mid-playback aborts, with the reset values above, on the next cycle (async for BUS_RST).
- Register writes during playback:
  - SIZE, REPEAT and WAIT are sampled live. A change takes effect at the next comparison.
  - Memory writes during playback are allowed.

Test Plan:
- OUT_BITS=8; mem[0..3]=11,22,33,44; SIZE=4, REPEAT=1; write addr1 -> SEQ_OUT 0x11,0x22,0x33,0x44 on cycles T+2..T+5, then 0; DONE 0->1; SEQ_BUSY high for 4 cycles.
- REPEAT=3, WAIT=2, SIZE=2 (AA,BB) -> AA,BB,0,0,AA,BB,0,0,AA,BB then idle; DONE set once at end.
- EN_EXT_START=0 then pulse SEQ_EXT_START -> no output. Set EN=1 and pulse -> playback starts with the same T+2 latency. Pulse again mid-run -> ignored.
- OUT_BITS=16; bytes 12,34,56,78 at mem 0..3; SIZE=2 -> SEQ_OUT 0x1234, 0x5678; bus readback of addr 16..19 returns 12,34,56,78 one cycle after BUS_RD.
- REPEAT=0 looping; assert BUS_RST asynchronously mid-word -> SEQ_OUT=0 and SEQ_BUSY=0 immediately, DONE=1, SIZE back to default; repeat the check with soft reset (write addr0) -> same result on the next edge.
- SIZE=0 with START -> SEQ_BUSY stays 0, DONE stays 1. Bus START during RUN at word 5 -> word 0 appears 2 cycles later.

Source files
------------

// File: rtl/seq_gen_core_sync.sv
// Sequence generator: a bus-writable pattern memory is played out one word per cycle on SEQ_OUT,
// with programmable word count, pass count and inter-pass gap.
module seq_gen_core_sync #(
    parameter int MEM_BYTES = 8 * 1024,
    parameter int ABUSWIDTH = 16,
    parameter int OUT_BITS  = 8
) (
    input  logic                 BUS_CLK,
    input  logic                 BUS_RST,
    input  logic [ABUSWIDTH-1:0] BUS_ADD,
    input  logic [7:0]           BUS_DATA_IN,
    input  logic                 BUS_RD,
    input  logic                 BUS_WR,
    output logic [7:0]           BUS_DATA_OUT,
    input  logic                 SEQ_EXT_START,
    output logic [OUT_BITS-1:0]  SEQ_OUT,
    output logic                 SEQ_BUSY
);

    localparam int N         = OUT_BITS / 8;
    localparam int DEPTH     = MEM_BYTES / N;
    localparam int MEM_AW    = $clog2(MEM_BYTES);
    localparam int ROW_AW    = $clog2(DEPTH);
    localparam int MEM_END   = 16 + MEM_BYTES;
    localparam logic [15:0] SIZE_RST = 16'(DEPTH);

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_WAIT} state_t;

    // Bus: BUS_WR/BUS_RD are single-cycle strobes; read data appears the cycle after BUS_RD.
    logic              reg_hit, mem_hit;
    logic [3:0]        reg_idx;
    logic [MEM_AW-1:0] mem_off;
    logic [ROW_AW-1:0] bus_row_addr;
    logic [1:0]        bus_lane;
    logic              soft_rst, start_cmd, start_go;

    assign reg_hit      = BUS_ADD < ABUSWIDTH'(16);
    assign mem_hit      = !reg_hit && (BUS_ADD < ABUSWIDTH'(MEM_END));
    assign reg_idx      = BUS_ADD[3:0];
    assign mem_off      = MEM_AW'(BUS_ADD - ABUSWIDTH'(16));
    assign bus_row_addr = ROW_AW'(mem_off / MEM_AW'(N));
    assign bus_lane     = 2'(mem_off % MEM_AW'(N));
    assign soft_rst     = BUS_WR && reg_hit && (reg_idx == 4'd0);
    assign start_cmd    = BUS_WR && reg_hit && (reg_idx == 4'd1);

    logic        en_ext;
    logic [15:0] size;
    logic [7:0]  rep_cnt;
    logic [15:0] wait_len;
    logic [7:0]  gp [8];

    always_ff @(posedge BUS_CLK or posedge BUS_RST) begin
        if (BUS_RST) begin
            en_ext   <= 1'b0;
            size     <= SIZE_RST;
            rep_cnt  <= 8'd1;
            wait_len <= 16'd0;
            for (int i = 0; i < 8; i++) gp[i] <= 8'h00;
        end else if (soft_rst) begin
            en_ext   <= 1'b0;
            size     <= SIZE_RST;
            rep_cnt  <= 8'd1;
            wait_len <= 16'd0;
            for (int i = 0; i < 8; i++) gp[i] <= 8'h00;
        end else if (BUS_WR && reg_hit) begin
            case (reg_idx)
                4'd2:    en_ext <= BUS_DATA_IN[0];
                4'd3:    size[7:0] <= BUS_DATA_IN;
                4'd4:    size[15:8] <= BUS_DATA_IN;
                4'd5:    rep_cnt <= BUS_DATA_IN;
                4'd6:    wait_len[7:0] <= BUS_DATA_IN;
                4'd7:    wait_len[15:8] <= BUS_DATA_IN;
                4'd8, 4'd9, 4'd10, 4'd11, 4'd12, 4'd13, 4'd14, 4'd15:
                         gp[reg_idx[2:0]] <= BUS_DATA_IN;
                default: ;
            endcase
        end
    end

    // Sequencer
    state_t      state, state_n;
    logic [15:0] word_cnt, wait_cnt;
    logic [7:0]  pass_cnt;
    logic        done, rd_en, rd_valid;
    logic        wc_last, pass_last, wait_last;
    logic [ROW_AW-1:0] seq_ptr;
    wire  [N*8-1:0] seq_row;
    wire  [N*8-1:0] bus_row;

    // Live comparisons so register changes mid-playback apply at the next check.
    assign wc_last   = ({1'b0, word_cnt} + 17'd1) >= {1'b0, size};
    assign pass_last = (rep_cnt != 8'd0) && (({1'b0, pass_cnt} + 9'd1) >= {1'b0, rep_cnt});
    assign wait_last = ({1'b0, wait_cnt} + 17'd1) >= {1'b0, wait_len};
    assign start_go  = start_cmd || (en_ext && SEQ_EXT_START && state == ST_IDLE);
    assign seq_ptr   = ROW_AW'(word_cnt);

    always_ff @(posedge BUS_CLK or posedge BUS_RST) begin
        if (BUS_RST)       state <= ST_IDLE;
        else if (soft_rst) state <= ST_IDLE;
        else               state <= state_n;
    end

    always_comb begin
        state_n = state;
        if (start_go) begin
            state_n = (size == 16'd0) ? ST_IDLE : ST_RUN;
        end else begin
            case (state)
                ST_RUN:
                    if (wc_last) begin
                        if (pass_last)             state_n = ST_IDLE;
                        else if (wait_len != 16'd0) state_n = ST_WAIT;
                        else                       state_n = ST_RUN;
                    end
                ST_WAIT:
                    if (wait_last) state_n = ST_RUN;
                default: ;
            endcase
        end
    end

    always_comb begin
        SEQ_BUSY = (state != ST_IDLE);
        rd_en    = (state == ST_RUN);
    end

    always_ff @(posedge BUS_CLK or posedge BUS_RST) begin
        if (BUS_RST) begin
            word_cnt <= 16'd0;
            pass_cnt <= 8'd0;
            wait_cnt <= 16'd0;
            done     <= 1'b1;
            rd_valid <= 1'b0;
            SEQ_OUT  <= '0;
        end else if (soft_rst) begin
            word_cnt <= 16'd0;
            pass_cnt <= 8'd0;
            wait_cnt <= 16'd0;
            done     <= 1'b1;
            rd_valid <= 1'b0;
            SEQ_OUT  <= '0;
        end else begin
            rd_valid <= rd_en;
            SEQ_OUT  <= rd_valid ? seq_row : '0;
            if (start_go) begin
                word_cnt <= 16'd0;
                pass_cnt <= 8'd0;
                wait_cnt <= 16'd0;
                done     <= (size == 16'd0);
            end else if (state == ST_RUN) begin
                if (wc_last) begin
                    word_cnt <= 16'd0;
                    pass_cnt <= pass_cnt + 8'd1;
                    wait_cnt <= 16'd0;
                    if (pass_last) done <= 1'b1;
                end else begin
                    word_cnt <= word_cnt + 16'd1;
                end
            end else if (state == ST_WAIT) begin
                wait_cnt <= wait_cnt + 16'd1;
            end
        end
    end

    // One byte-wide bank per word lane; lane 0 holds the lowest byte address (word MSB).
    for (genvar i = 0; i < N; i++) begin : g_bank
        logic [7:0] ram [DEPTH];
        logic [7:0] seq_q, bus_q;
        always_ff @(posedge BUS_CLK) begin
            if (BUS_WR && mem_hit && bus_lane == 2'(i)) ram[bus_row_addr] <= BUS_DATA_IN;
            if (BUS_RD) bus_q <= ram[bus_row_addr];
            seq_q <= ram[seq_ptr];
        end
        assign seq_row[(N-1-i)*8 +: 8] = seq_q;
        assign bus_row[i*8 +: 8]       = bus_q;
    end

    // Bus read-back
    logic [7:0] reg_rdata, reg_q;
    logic       rd_reg_q, rd_mem_q;
    logic [1:0] rd_lane_q;

    always_comb begin
        reg_rdata = 8'h00;
        case (reg_idx)
            4'd0:    reg_rdata = 8'h00;
            4'd1:    reg_rdata = {7'b0, done};
            4'd2:    reg_rdata = {7'b0, en_ext};
            4'd3:    reg_rdata = size[7:0];
            4'd4:    reg_rdata = size[15:8];
            4'd5:    reg_rdata = rep_cnt;
            4'd6:    reg_rdata = wait_len[7:0];
            4'd7:    reg_rdata = wait_len[15:8];
            default: reg_rdata = gp[reg_idx[2:0]];
        endcase
    end

    always_ff @(posedge BUS_CLK or posedge BUS_RST) begin
        if (BUS_RST) begin
            reg_q     <= 8'h00;
            rd_reg_q  <= 1'b0;
            rd_mem_q  <= 1'b0;
            rd_lane_q <= 2'd0;
        end else if (BUS_RD) begin
            reg_q     <= reg_rdata;
            rd_reg_q  <= reg_hit;
            rd_mem_q  <= mem_hit;
            rd_lane_q <= bus_lane;
        end
    end

    always_comb begin
        BUS_DATA_OUT = 8'h00;
        if (rd_reg_q) begin
            BUS_DATA_OUT = reg_q;
        end else if (rd_mem_q) begin
            for (int i = 0; i < N; i++)
                if (rd_lane_q == 2'(i)) BUS_DATA_OUT = bus_row[i*8 +: 8];
        end
    end

endmodule

// File: tb/tb_seq_gen_core_sync.sv
// Bench for seq_gen_core_sync: an 8-bit and a 16-bit instance checked cycle by cycle
// against a stream model built from the register settings and a shadow of the pattern memory.
module tb_seq_gen_core_sync;

    localparam int MB = 256;

    logic        clk, rst;
    logic [15:0] bus_add;
    logic [7:0]  bus_din;
    logic        rd8, wr8, rd16, wr16, ext8, ext16;
    logic [7:0]  dout8, dout16;
    logic [7:0]  out8;
    logic [15:0] out16;
    logic        busy8, busy16;

    seq_gen_core_sync #(.MEM_BYTES(MB), .ABUSWIDTH(16), .OUT_BITS(8)) dut8 (
        .BUS_CLK(clk), .BUS_RST(rst), .BUS_ADD(bus_add), .BUS_DATA_IN(bus_din),
        .BUS_RD(rd8), .BUS_WR(wr8), .BUS_DATA_OUT(dout8),
        .SEQ_EXT_START(ext8), .SEQ_OUT(out8), .SEQ_BUSY(busy8)
    );

    seq_gen_core_sync #(.MEM_BYTES(MB), .ABUSWIDTH(16), .OUT_BITS(16)) dut16 (
        .BUS_CLK(clk), .BUS_RST(rst), .BUS_ADD(bus_add), .BUS_DATA_IN(bus_din),
        .BUS_RD(rd16), .BUS_WR(wr16), .BUS_DATA_OUT(dout16),
        .SEQ_EXT_START(ext16), .SEQ_OUT(out16), .SEQ_BUSY(busy16)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // reference model state
    logic [7:0]  m_mem [2][MB];
    int          m_size [2];
    int          m_rep [2];
    int          m_wait [2];
    logic [31:0] exp_q [$];
    int          n_total = 0;
    int          n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic void model_reset(input int sel);
        m_size[sel] = (sel == 0) ? MB : MB / 2;
        m_rep[sel]  = 1;
        m_wait[sel] = 0;
    endfunction

    // driver tasks
    task automatic bus_write(input int sel, input int addr, input int data);
        bus_add = 16'(addr);
        bus_din = 8'(data);
        if (sel == 0) wr8 = 1'b1; else wr16 = 1'b1;
        tick();
        wr8 = 1'b0;
        wr16 = 1'b0;
        case (addr)
            0: model_reset(sel);
            3: m_size[sel] = (m_size[sel] & 32'hff00) | (data & 255);
            4: m_size[sel] = (m_size[sel] & 32'h00ff) | ((data & 255) << 8);
            5: m_rep[sel]  = data & 255;
            6: m_wait[sel] = (m_wait[sel] & 32'hff00) | (data & 255);
            7: m_wait[sel] = (m_wait[sel] & 32'h00ff) | ((data & 255) << 8);
            default: if (addr >= 16 && addr < 16 + MB) m_mem[sel][addr-16] = 8'(data);
        endcase
    endtask

    task automatic bus_read(input int sel, input int addr, output logic [7:0] d);
        bus_add = 16'(addr);
        if (sel == 0) rd8 = 1'b1; else rd16 = 1'b1;
        tick();
        rd8 = 1'b0;
        rd16 = 1'b0;
        d = (sel == 0) ? dout8 : dout16;
    endtask

    task automatic set_cfg(input int sel, input int size, input int rep, input int gap);
        bus_write(sel, 3, size & 255);
        bus_write(sel, 4, size >> 8);
        bus_write(sel, 5, rep);
        bus_write(sel, 6, gap & 255);
        bus_write(sel, 7, gap >> 8);
    endtask

    function automatic logic [31:0] word_of(input int sel, input int k);
        int nb, depth, w;
        logic [31:0] v;
        nb = (sel == 0) ? 1 : 2;
        depth = MB / nb;
        w = k % depth;
        v = 0;
        for (int i = 0; i < nb; i++) v = (v << 8) | 32'(m_mem[sel][w*nb + i]);
        return v;
    endfunction

    // Expected SEQ_OUT stream: one entry per busy cycle (words during passes, zeros in gaps).
    function automatic void build_stream(input int sel);
        exp_q.delete();
        for (int p = 0; p < m_rep[sel]; p++) begin
            for (int k = 0; k < m_size[sel]; k++) exp_q.push_back(word_of(sel, k));
            if (p < m_rep[sel] - 1)
                for (int g = 0; g < m_wait[sel]; g++) exp_q.push_back(32'd0);
        end
    endfunction

    // Trigger a playback and compare SEQ_OUT/SEQ_BUSY every cycle. restart_at issues a bus START
    // while running; ext_at pulses the external trigger (must be ignored while busy).
    task automatic run_check(input int sel, input int trig, input int restart_at, input int ext_at);
        int len, r, idx, ncyc;
        logic [31:0] exp_out, got_out;
        logic        exp_busy, got_busy;
        logic [7:0]  d;
        build_stream(sel);
        len = exp_q.size();
        r = (restart_at >= 0) ? restart_at + 1 : -1;
        ncyc = len + 4 + ((r >= 0) ? r : 0);
        if (trig == 0) begin
            bus_write(sel, 1, 0);
        end else begin
            if (sel == 0) ext8 = 1'b1; else ext16 = 1'b1;
            tick();
            ext8 = 1'b0;
            ext16 = 1'b0;
        end
        for (int j = 0; j < ncyc; j++) begin
            idx = (r >= 0 && j >= r + 2) ? j - r - 2 : j - 2;
            exp_out = (idx >= 0 && idx < len) ? exp_q[idx] : 32'd0;
            exp_busy = (r >= 0 && j >= r) ? ((j - r) < len) : (j < len);
            got_out = (sel == 0) ? {24'd0, out8} : {16'd0, out16};
            got_busy = (sel == 0) ? busy8 : busy16;
            check($sformatf("seq_out sel%0d cyc%0d", sel, j), got_out, exp_out);
            check($sformatf("busy sel%0d cyc%0d", sel, j), {31'd0, got_busy}, {31'd0, exp_busy});
            if (j == restart_at) begin
                bus_add = 16'd1;
                if (sel == 0) wr8 = 1'b1; else wr16 = 1'b1;
            end
            if (j == ext_at) begin
                if (sel == 0) ext8 = 1'b1; else ext16 = 1'b1;
            end
            tick();
            wr8 = 1'b0; wr16 = 1'b0; ext8 = 1'b0; ext16 = 1'b0;
        end
        bus_read(sel, 1, d);
        check($sformatf("done after run sel%0d", sel), {24'd0, d}, 32'd1);
    endtask

    initial begin
        logic [7:0] d;
        int sel, size;
        rst = 1'b1;
        bus_add = 16'd0; bus_din = 8'd0;
        rd8 = 1'b0; wr8 = 1'b0; rd16 = 1'b0; wr16 = 1'b0; ext8 = 1'b0; ext16 = 1'b0;
        model_reset(0);
        model_reset(1);
        repeat (3) tick();
        rst = 1'b0;
        tick();

        // reset state
        check("rst out8", {24'd0, out8}, 32'd0);
        check("rst busy8", {31'd0, busy8}, 32'd0);
        check("rst out16", {16'd0, out16}, 32'd0);
        check("rst busy16", {31'd0, busy16}, 32'd0);
        bus_read(0, 0, d); check("version", {24'd0, d}, 32'd0);
        bus_read(0, 1, d); check("rst done", {24'd0, d}, 32'd1);
        bus_read(0, 3, d); check("rst size lo 8", {24'd0, d}, 32'h00);
        bus_read(0, 4, d); check("rst size hi 8", {24'd0, d}, 32'h01);
        bus_read(0, 5, d); check("rst repeat", {24'd0, d}, 32'd1);
        bus_read(1, 3, d); check("rst size lo 16", {24'd0, d}, 32'h80);
        bus_read(1, 4, d); check("rst size hi 16", {24'd0, d}, 32'h00);
        bus_write(0, 9, 8'h5a);
        bus_read(0, 9, d); check("gp reg", {24'd0, d}, 32'h5a);

        // fill both memories so every word the model may need is known
        for (int s = 0; s < 2; s++)
            for (int a = 0; a < MB; a++) bus_write(s, 16 + a, $urandom_range(0, 255));

        // basic single pass
        bus_write(0, 16, 8'h11); bus_write(0, 17, 8'h22);
        bus_write(0, 18, 8'h33); bus_write(0, 19, 8'h44);
        set_cfg(0, 4, 1, 0);
        run_check(0, 0, -1, -1);
        bus_write(0, 1, 0);
        bus_read(0, 1, d); check("done cleared", {24'd0, d}, 32'd0);
        repeat (8) tick();
        bus_read(0, 1, d); check("done set", {24'd0, d}, 32'd1);

        // repeats with gap
        bus_write(0, 16, 8'haa); bus_write(0, 17, 8'hbb);
        set_cfg(0, 2, 3, 2);
        run_check(0, 0, -1, -1);

        // external trigger disabled, then enabled with a mid-run pulse
        bus_write(0, 2, 0);
        ext8 = 1'b1; tick(); ext8 = 1'b0;
        for (int j = 0; j < 6; j++) begin
            check("ext disabled out", {24'd0, out8}, 32'd0);
            check("ext disabled busy", {31'd0, busy8}, 32'd0);
            tick();
        end
        bus_write(0, 2, 1);
        set_cfg(0, 4, 1, 0);
        run_check(0, 1, -1, 2);

        // 16-bit big-endian words and bus readback
        bus_write(1, 16, 8'h12); bus_write(1, 17, 8'h34);
        bus_write(1, 18, 8'h56); bus_write(1, 19, 8'h78);
        set_cfg(1, 2, 1, 0);
        run_check(1, 0, -1, -1);
        bus_read(1, 16, d); check("rdback 16", {24'd0, d}, 32'h12);
        bus_read(1, 17, d); check("rdback 17", {24'd0, d}, 32'h34);
        bus_read(1, 18, d); check("rdback 18", {24'd0, d}, 32'h56);
        bus_read(1, 19, d); check("rdback 19", {24'd0, d}, 32'h78);
        bus_read(0, 16 + MB, d); check("rd beyond mem", {24'd0, d}, 32'd0);

        // bus START while running restarts at word 0
        set_cfg(0, 10, 1, 0);
        run_check(0, 0, 5, -1);

        // SIZE = 0 never starts
        set_cfg(0, 0, 1, 0);
        bus_write(0, 1, 0);
        for (int j = 0; j < 5; j++) begin
            check("size0 busy", {31'd0, busy8}, 32'd0);
            check("size0 out", {24'd0, out8}, 32'd0);
            tick();
        end
        bus_read(0, 1, d); check("size0 done", {24'd0, d}, 32'd1);

        // SIZE beyond depth wraps the pointer
        set_cfg(1, MB / 2 + 2, 1, 0);
        run_check(1, 0, -1, -1);

        // randomized configurations
        for (int it = 0; it < 10; it++) begin
            sel = $urandom_range(0, 1);
            size = $urandom_range(1, 6);
            for (int b = 0; b < size * (sel + 1); b++) bus_write(sel, 16 + b, $urandom_range(0, 255));
            set_cfg(sel, size, $urandom_range(1, 3), $urandom_range(0, 3));
            run_check(sel, 0, -1, -1);
        end

        // asynchronous reset during endless playback
        set_cfg(0, 3, 0, 1);
        bus_write(0, 1, 0);
        repeat (6) tick();
        check("loop busy before rst", {31'd0, busy8}, 32'd1);
        #3 rst = 1'b1;
        #1;
        check("async rst out", {24'd0, out8}, 32'd0);
        check("async rst busy", {31'd0, busy8}, 32'd0);
        #2 rst = 1'b0;
        model_reset(0);
        model_reset(1);
        tick();
        bus_read(0, 1, d); check("async rst done", {24'd0, d}, 32'd1);
        bus_read(0, 3, d); check("async rst size lo", {24'd0, d}, 32'h00);
        bus_read(0, 4, d); check("async rst size hi", {24'd0, d}, 32'h01);
        bus_read(0, 9, d); check("async rst gp", {24'd0, d}, 32'h00);

        // soft reset during endless playback
        set_cfg(0, 3, 0, 0);
        bus_write(0, 1, 0);
        repeat (5) tick();
        check("loop busy before soft", {31'd0, busy8}, 32'd1);
        bus_write(0, 0, 8'hff);
        check("soft rst out", {24'd0, out8}, 32'd0);
        check("soft rst busy", {31'd0, busy8}, 32'd0);
        bus_read(0, 1, d); check("soft rst done", {24'd0, d}, 32'd1);
        bus_read(0, 3, d); check("soft rst size lo", {24'd0, d}, 32'h00);
        bus_read(0, 4, d); check("soft rst size hi", {24'd0, d}, 32'h01);
        bus_read(0, 5, d); check("soft rst repeat", {24'd0, d}, 32'd1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
